// File: rtl/fwd_power_monitor.sv
// Forward-power monitor: boxcar moving average, decaying peak hold and a
// sticky over-power trip. It consumes 12-bit VFWD readings from the ADC
// interface and runs on the same clock.
//
// Ports:
//   clock        system clock
//   nreset       asynchronous active-low reset
//   sample       12-bit unsigned forward-power reading
//   sample_valid one-clock strobe, sample valid this cycle
//   threshold    12-bit over-power limit, used when a sample is accepted
//   clear_trip   level, clears trip and the consecutive-over counter
//   avg          moving average of the last 2^AVG_LOG2 accepted samples
//   avg_valid    one-clock strobe when avg updates
//   peak         peak-hold value, decays 1 LSB every DECAY_DIV clocks
//   trip         sticky over-power flag
module fwd_power_monitor #(
  parameter int unsigned AVG_LOG2   = 4,
  parameter int unsigned DECAY_DIV  = 48000,
  parameter int unsigned TRIP_COUNT = 4
) (
  input  logic        clock,
  input  logic        nreset,
  input  logic [11:0] sample,
  input  logic        sample_valid,
  input  logic [11:0] threshold,
  input  logic        clear_trip,
  output logic [11:0] avg,
  output logic        avg_valid,
  output logic [11:0] peak,
  output logic        trip
);

  localparam int unsigned N  = 1 << AVG_LOG2;
  localparam int unsigned SW = 12 + AVG_LOG2;
  localparam int unsigned DW = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam int unsigned TW = $clog2(TRIP_COUNT + 1);
  localparam logic [DW-1:0] DEC_LAST = DW'(DECAY_DIV - 1);
  localparam logic [TW-1:0] TRIP_MAX = TW'(TRIP_COUNT);

  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_OUT} state_e;

  state_e               state_q;
  logic [11:0]          smp_q;
  logic [SW-1:0]        sum_q, sum_d;
  logic [AVG_LOG2-1:0]  ptr_q;
  logic [11:0]          ring_q [N];
  logic [11:0]          avg_q;
  logic                 avg_valid_q;
  logic [11:0]          peak_q, peak_d;
  logic [DW-1:0]        dcnt_q, dcnt_d;
  logic [TW-1:0]        tcnt_q, tcnt_d, tcnt_inc;
  logic                 trip_q, trip_d;
  logic                 accept, dec_tick, over;
  logic [11:0]          oldest;

  always_comb begin
    accept   = (state_q == ST_IDLE) && sample_valid;
    oldest   = ring_q[ptr_q];
    sum_d    = sum_q + SW'(smp_q) - SW'(oldest);

    // Decay counter free-runs; a new peak restarts it and beats a
    // coincident decay tick.
    dec_tick = (dcnt_q == DEC_LAST);
    dcnt_d   = dec_tick ? '0 : dcnt_q + 1'b1;
    peak_d   = peak_q;
    if (dec_tick && (peak_q != '0)) peak_d = peak_q - 1'b1;
    if (accept && (sample >= peak_q)) begin
      peak_d = sample;
      dcnt_d = '0;
    end

    // Completing the run sets trip even when clear_trip is asserted.
    over     = sample > threshold;
    tcnt_inc = (tcnt_q == TRIP_MAX) ? tcnt_q : tcnt_q + 1'b1;
    tcnt_d   = tcnt_q;
    trip_d   = trip_q;
    if (accept && over && (tcnt_inc == TRIP_MAX)) begin
      tcnt_d = TRIP_MAX;
      trip_d = 1'b1;
    end else if (clear_trip) begin
      tcnt_d = '0;
      trip_d = 1'b0;
    end else if (accept) begin
      tcnt_d = over ? tcnt_inc : '0;
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q     <= ST_IDLE;
      smp_q       <= '0;
      sum_q       <= '0;
      ptr_q       <= '0;
      ring_q      <= '{default: '0};
      avg_q       <= '0;
      avg_valid_q <= 1'b0;
      peak_q      <= '0;
      dcnt_q      <= '0;
      tcnt_q      <= '0;
      trip_q      <= 1'b0;
    end else begin
      avg_valid_q <= 1'b0;
      peak_q      <= peak_d;
      dcnt_q      <= dcnt_d;
      tcnt_q      <= tcnt_d;
      trip_q      <= trip_d;
      case (state_q)
        ST_IDLE: begin
          if (sample_valid) begin
            smp_q   <= sample;
            state_q <= ST_CALC;
          end
        end
        ST_CALC: begin
          sum_q         <= sum_d;
          ring_q[ptr_q] <= smp_q;
          ptr_q         <= ptr_q + 1'b1;
          // avg and its strobe are loaded on entry to OUT so that they are
          // visible during the OUT cycle itself.
          avg_q         <= sum_d[SW-1:AVG_LOG2];
          avg_valid_q   <= 1'b1;
          state_q       <= ST_OUT;
        end
        ST_OUT:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign avg       = avg_q;
  assign avg_valid = avg_valid_q;
  assign peak      = peak_q;
  assign trip      = trip_q;

endmodule

// File: tb/tb_fwd_power_monitor.sv
module tb_fwd_power_monitor;

  localparam int D  = 10;
  localparam int TC = 4;

  logic        clock = 1'b0;
  logic        nreset = 1'b1;
  logic [11:0] sample = '0;
  logic        sample_valid = 1'b0;
  logic [11:0] threshold = '0;
  logic        clear_trip = 1'b0;
  logic [11:0] avg, peak;
  logic        avg_valid, trip;

  int errors = 0;
  int checks = 0;

  fwd_power_monitor #(.AVG_LOG2(4), .DECAY_DIV(D), .TRIP_COUNT(TC)) dut (
    .clock(clock), .nreset(nreset), .sample(sample), .sample_valid(sample_valid),
    .threshold(threshold), .clear_trip(clear_trip), .avg(avg), .avg_valid(avg_valid),
    .peak(peak), .trip(trip));

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Window kept as a queue of the last 16 accepted samples; peak is
  // p0 minus one per D clocks since it was captured, floored at zero.
  int m_q[$];
  int m_avg, m_pend, m_av, m_trip, m_cnt;
  int p0, t0, n, last_acc;
  int m_cur, m_s, m_tot, m_nc;
  bit m_over;

  function automatic int peak_at(input int k);
    int v;
    v = p0 - (k - t0) / D;
    return (v < 0) ? 0 : v;
  endfunction

  always @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      m_q.delete();
      for (int i = 0; i < 16; i++) m_q.push_back(0);
      m_avg = 0; m_pend = 0; m_av = 0; m_trip = 0; m_cnt = 0;
      p0 = 0; t0 = 0; n = 0; last_acc = -10;
    end else begin
      n++;
      m_cur = peak_at(n - 1);
      m_av  = (n == last_acc + 1) ? 1 : 0;
      if (m_av == 1) m_avg = m_pend;
      if (sample_valid && (n - last_acc >= 3)) begin
        m_s = int'(sample);
        last_acc = n;
        void'(m_q.pop_front());
        m_q.push_back(m_s);
        m_tot = 0;
        foreach (m_q[i]) m_tot += m_q[i];
        m_pend = m_tot / 16;
        if (m_s >= m_cur) begin p0 = m_s; t0 = n; end
        m_over = (m_s > int'(threshold));
        m_nc = m_over ? ((m_cnt + 1 > TC) ? TC : m_cnt + 1) : 0;
        if (m_over && m_nc == TC) begin m_trip = 1; m_cnt = TC; end
        else if (clear_trip) begin m_trip = 0; m_cnt = 0; end
        else m_cnt = m_nc;
      end else if (clear_trip) begin
        m_trip = 0; m_cnt = 0;
      end
    end
  end

  always @(negedge clock) begin
    if (nreset) begin
      check("model_avg", avg, m_avg);
      check("model_avg_valid", avg_valid, m_av);
      check("model_peak", peak, peak_at(n));
      check("model_trip", trip, m_trip);
    end
  end

  // ---------------- helpers ----------------
  task automatic idle(input int k);
    repeat (k) @(negedge clock);
  endtask

  task automatic strobe(input int s, input int thr);
    sample = 12'(s); threshold = 12'(thr); sample_valid = 1'b1;
    @(negedge clock);
    sample_valid = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_avg"}, avg, 0);
    check({tag, "_avg_valid"}, avg_valid, 0);
    check({tag, "_peak"}, peak, 0);
    check({tag, "_trip"}, trip, 0);
  endtask

  task automatic do_reset();
    #2 nreset = 1'b0;
    #1 check_zero("reset");
    @(negedge clock);
    nreset = 1'b1;
  endtask

  typedef struct {
    int s; int thr; int exp_avg; int exp_peak; int exp_trip;
  } vec_t;

  vec_t tbl[$];
  int   tr_s[8]   = '{3001, 3001, 3001, 2999, 3001, 3001, 3001, 3001};
  int   tr_avg[8] = '{187, 375, 562, 750, 937, 1125, 1312, 1500};
  int   hold_e[6] = '{5, 4, 3, 2, 1, 0};
  int   step_e[6] = '{4, 3, 2, 1, 0, 0};
  int   lat, pulses;
  bit   seen;

  initial begin
    #1 nreset = 1'b0;
    #1 check_zero("por");
    @(negedge clock);
    nreset = 1'b1;

    // ---- table: average, peak and trip per accepted sample ----
    tbl.push_back('{1600, 3000, 100, 1600, 0});
    for (int k = 1; k <= 16; k++)
      tbl.push_back('{2000, 3000, (k < 16) ? (1600 + 2000 * k) / 16 : 2000, 2000, 0});
    for (int k = 1; k <= 16; k++)
      tbl.push_back('{0, 3000, 2000 - 125 * k, 2000 - 8 * k, 0});
    for (int k = 0; k < 8; k++)
      tbl.push_back('{tr_s[k], 3000, tr_avg[k], tr_s[k], (k == 7) ? 1 : 0});

    foreach (tbl[i]) begin
      sample = 12'(tbl[i].s); threshold = 12'(tbl[i].thr); sample_valid = 1'b1;
      @(negedge clock);
      sample_valid = 1'b0;
      lat = 1; seen = 1'b0;
      while (!seen && lat < 6) begin
        if (avg_valid) seen = 1'b1;
        else begin @(negedge clock); lat++; end
      end
      check("tbl_latency", lat, 2);
      check("tbl_avg", avg, tbl[i].exp_avg);
      check("tbl_peak", peak, tbl[i].exp_peak);
      check("tbl_trip", trip, tbl[i].exp_trip);
      idle(80 - lat);
    end

    // ---- clear_trip pulse, set-wins coincidence, held clear ----
    clear_trip = 1'b1; @(negedge clock); clear_trip = 1'b0;
    check("clear_pulse", trip, 0);
    for (int k = 0; k < 3; k++) begin strobe(3500, 3000); idle(3); end
    check("pre_complete", trip, 0);
    sample = 12'd3500; threshold = 12'd3000; sample_valid = 1'b1; clear_trip = 1'b1;
    @(negedge clock);
    sample_valid = 1'b0; clear_trip = 1'b0;
    check("set_beats_clear", trip, 1);
    idle(3);
    clear_trip = 1'b1; idle(2); clear_trip = 1'b0;
    check("held_clear", trip, 0);

    // ---- peak decay with DECAY_DIV=10 ----
    do_reset();
    strobe(5, 4095);
    for (int m = 0; m < 6; m++) begin
      idle(9);
      check("decay_hold", peak, hold_e[m]);
      idle(1);
      check("decay_step", peak, step_e[m]);
    end
    do_reset();
    strobe(5, 4095);
    idle(29);
    strobe(3, 4095);
    check("tick_coincide", peak, 3);
    idle(9);
    check("tick_restart_hold", peak, 3);
    idle(1);
    check("tick_restart_step", peak, 2);

    // ---- strobes during CALC and OUT are dropped ----
    do_reset();
    sample = 12'd100; threshold = 12'd3000; sample_valid = 1'b1; pulses = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      if (avg_valid) pulses++;
      if (c < 2) sample = 12'd4000;
      else sample_valid = 1'b0;
    end
    check("busy_pulses", pulses, 1);
    check("busy_avg", avg, 6);
    check("busy_peak", peak, 100);
    strobe(0, 3000);
    idle(3);
    check("busy_sum_kept", avg, 6);

    // ---- reset during CALC ----
    for (int k = 0; k < 4; k++) begin strobe(4000, 3000); idle(3); end
    check("pre_reset_trip", trip, 1);
    sample = 12'd2500; sample_valid = 1'b1;
    @(negedge clock);
    sample_valid = 1'b0;
    #1 nreset = 1'b0;
    #1 check_zero("calc_reset");
    @(negedge clock);
    nreset = 1'b1;
    strobe(160, 3000);
    idle(1);
    check("post_reset_valid", avg_valid, 1);
    check("post_reset_avg", avg, 10);

    // ---- randomized traffic against the model ----
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      sample_valid = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 9))
        0:       sample = 12'd4095;
        1:       sample = 12'd0;
        default: sample = 12'($urandom_range(1500, 2600));
      endcase
      threshold  = 12'($urandom_range(1800, 2300));
      clear_trip = ($urandom_range(0, 29) == 0);
      @(negedge clock);
    end
    sample_valid = 1'b0; clear_trip = 1'b0;
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
